// File: rtl/seq_shift.sv
// Multi-cycle barrel-less shifter: one 1-bit LSL/LSR/ASR/ROR step per clock.
// Rotate (mode 11) is compiled in only when SEQ_SHIFT_ROTATE_EN is defined; otherwise mode 11 acts as LSR.
module seq_shift #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [SHAMT_W-1:0] amount,
    input  logic [WIDTH-1:0]   din,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dout,
    output logic               carry,
    output logic               zero,
    output logic [1:0]         state_dbg
);

    // start is a request pulse, not a valid/ready pair: it is accepted only in IDLE or
    // DONE and silently dropped while busy; done is the single-cycle "result valid" strobe.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [1:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            mode_q  <= '0;
            dout_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            dout_q  <= dout_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mode_d  = mode_q;
        dout_d  = dout_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    count_d = amount;
                    mode_d  = mode;
                    dout_d  = din;
                    carry_d = 1'b0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (count_q != '0) begin
                    count_d = count_q - SHAMT_W'(1);
                    case (mode_q)
                        2'b00: begin
                            dout_d  = {dout_q[WIDTH-2:0], 1'b0};
                            carry_d = dout_q[WIDTH-1];
                        end
                        2'b10: begin
                            dout_d  = {dout_q[WIDTH-1], dout_q[WIDTH-1:1]};
                            carry_d = dout_q[0];
                        end
`ifdef SEQ_SHIFT_ROTATE_EN
                        2'b11: begin
                            dout_d  = {dout_q[0], dout_q[WIDTH-1:1]};
                            carry_d = dout_q[0];
                        end
`endif
                        default: begin
                            // LSR, and mode 11 when rotate is not built in
                            dout_d  = {1'b0, dout_q[WIDTH-1:1]};
                            carry_d = dout_q[0];
                        end
                    endcase
                end else begin
                    state_d = DONE;
                    zero_d  = (dout_q == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign dout      = dout_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_shift.sv
// Bench for seq_shift: directed corner cases plus randomized operations checked by a
// scoreboard against an arithmetic reference model (honours SEQ_SHIFT_ROTATE_EN).
module tb_seq_shift;

    localparam int W  = 16;
    localparam int SW = 4;
    localparam int EW = 16 + 2 + W;  // {done_cycle, zero, carry, dout}

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [SW-1:0] amount;
    logic [W-1:0]  din;
    logic          busy, done, carry, zero;
    logic [W-1:0]  dout;
    logic [1:0]    state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [EW-1:0] exp_q[$];

    seq_shift #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .amount(amount), .din(din),
        .busy(busy), .done(done), .dout(dout), .carry(carry), .zero(zero),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [W+1:0] model(input logic [1:0] m, input logic [W-1:0] d, input int a);
        logic [W-1:0]   r;
        logic [W:0]     t;
        logic [2*W-1:0] dd;
        logic           c;
        case (m)
            2'b00: begin
                r = d << a;
                t = {1'b0, d} << a;
                c = (a == 0) ? 1'b0 : t[W];
            end
            2'b10: begin
                r = $signed(d) >>> a;
                t = $signed({d, 1'b0}) >>> a;
                c = (a == 0) ? 1'b0 : t[0];
            end
`ifdef SEQ_SHIFT_ROTATE_EN
            2'b11: begin
                dd = {d, d} >> (a % W);
                r  = dd[W-1:0];
                c  = (a == 0) ? 1'b0 : r[W-1];
            end
`endif
            default: begin
                r = d >> a;
                t = {d, 1'b0} >> a;
                c = (a == 0) ? 1'b0 : t[0];
            end
        endcase
        dd = '0;
        return {(r == '0), c, r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("dout", 32'(dout), 32'(e[W-1:0]));
                check("carry", 32'(carry), 32'(e[W]));
                check("zero", 32'(zero), 32'(e[W+1]));
                check("done_cycle", 32'(cyc[15:0]), 32'(e[EW-1:W+2]));
                check("busy_in_done", 32'(busy), 32'(0));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge with the DUT in IDLE or DONE; returns at the negedge where done is seen.
    task automatic run_op(input logic [1:0] m, input logic [W-1:0] d, input int a, input bit noise);
        start  = 1'b1;
        mode   = m;
        din    = d;
        amount = SW'(a);
        exp_q.push_back({16'(cyc + a + 2), model(m, d, a)});
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'(1));
        for (int i = 0; i < 40 && !done; i++) begin
            if (noise) begin
                start  = 1'($urandom_range(0, 1));
                din    = W'($urandom);
                mode   = 2'($urandom_range(0, 3));
                amount = SW'($urandom_range(0, 15));
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!done) begin
            check("done_timeout", 32'(done), 32'(1));
            exp_q.delete();
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            start  = 1'b0;
            din    = W'($urandom);
            amount = SW'($urandom_range(0, 15));
            @(negedge clk);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'b00; amount = '0; din = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_dout", 32'(dout), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_state", 32'(state_dbg), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        run_op(2'b00, 16'h8001, 1, 1'b0);
        idle_cycles(2);
        run_op(2'b10, 16'h8000, 4, 1'b0);
        run_op(2'b01, 16'h1234, 0, 1'b0);  // back-to-back from DONE
        idle_cycles(1);
        run_op(2'b11, 16'h0001, 1, 1'b0);
        idle_cycles(1);
        start = 1'b1;                      // starts while busy must be ignored
        run_op(2'b01, 16'hFFFF, 15, 1'b1);
        idle_cycles(1);

        // reset mid-operation: in-flight op discarded, no done afterwards
        start = 1'b1; mode = 2'b10; din = 16'h8000; amount = SW'(8);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_dout", 32'(dout), 32'(0));
        check("midrst_carry", 32'(carry), 32'(0));
        check("midrst_zero", 32'(zero), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_state", 32'(state_dbg), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        run_op(2'b00, 16'h0001, 2, 1'b0);  // accepted on the first edge after release
        idle_cycles(3);

        for (int k = 0; k < 150; k++) begin
            run_op(2'($urandom_range(0, 3)), W'($urandom), $urandom_range(0, 15),
                   1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) idle_cycles($urandom_range(1, 3));
        end

        idle_cycles(4);
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

endmodule
